// File: rtl/alu_acc_sequencer.sv
// ---------------------------------------------------------------------------
// alu_acc_sequencer
//
// Command sequencer that sits upstream of an 8-bit combinational ALU and turns
// it into a pipelined accumulate engine. Commands are buffered in a small FIFO;
// each one is issued to the ALU with the running accumulator as operand a and
// the command data as operand b. The ALU result (or the command data, for a
// load) is captured back into the accumulator and presented on a valid/ready
// result port.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready = FIFO not full)
//   cmd_load              1 = load accumulator with cmd_data, ALU bypassed
//   cmd_op                ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//   cmd_data              operand b / load value
//   alu_a/alu_b/alu_op    registered operands and op driven to the ALU
//   alu_result/alu_zero   combinational ALU outputs
//   res_valid/res_ready   result handshake
//   res_data/res_zero     result value and its zero flag
//   acc                   current accumulator
//   busy                  FIFO non-empty or a command in flight
// ---------------------------------------------------------------------------
module alu_acc_sequencer #(
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [DATA_W-1:0] acc,
    output logic              busy
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

    typedef struct packed {
        logic              load;
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        st_idle,
        st_exec,
        st_hold
    } state_t;

    state_t            state_q, state_d;
    cmd_t              fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, empty, push, pop, res_hs;
    logic              load_q;
    logic [DATA_W-1:0] exec_val;
    cmd_t              head;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign res_hs    = res_valid && res_ready;
    assign head      = fifo_mem[rd_ptr];

    // Value captured at the end of EXEC: loads bypass the ALU.
    assign exec_val  = load_q ? alu_b : alu_result;

    assign alu_a     = acc;
    assign busy      = (state_q != st_idle) || !empty;

    // ------------------------------------------------------------------
    // Next-state logic. A pop happens whenever a command is issued to the
    // ALU: from IDLE, or straight from HOLD once the current result drains.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            st_idle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = st_exec;
                end
            end
            st_exec: begin
                state_d = st_hold;
            end
            st_hold: begin
                if (res_hs) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = st_exec;
                    end else begin
                        state_d = st_idle;
                    end
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO. Pointers wrap naturally because the depth is a power
    // of two.
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; the pointers and count already
    // define which entries are valid, and a reset on the array would prevent
    // mapping it to plain RAM/flop-array cells.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_t'{load: cmd_load, op: cmd_op, data: cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand, accumulator and result registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_b     <= '0;
            alu_op    <= 2'b00;
            load_q    <= 1'b0;
            acc       <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (pop) begin
                alu_b  <= head.data;
                alu_op <= head.op;
                load_q <= head.load;
            end
            if (state_q == st_exec) begin
                acc       <= exec_val;
                res_data  <= exec_val;
                res_zero  <= load_q ? (alu_b == '0) : alu_zero;
                res_valid <= 1'b1;
            end else if ((state_q == st_hold) && res_hs) begin
                // Drop valid on every handshake; a follow-on command
                // raises it again after its EXEC cycle.
                res_valid <= 1'b0;
            end
        end
    end

endmodule
